rice_preproc: RTL and testbench

RICE_PREPROC -- requirements
Module: rice_preproc

---
 rtl/rice_preproc_if.sv | 13 +
 rtl/rice_preproc.sv | 115 +++++++++++
 tb/tb_rice_preproc.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/rice_preproc_if.sv
// Handshake and data bundle between a block source and the Rice unit-delay preprocessor.
interface rice_preproc_if;
    logic         start;
    logic [5:0]   j;
    logic [319:0] xin;
    logic [9:0]   xref;
    logic [319:0] symbol;
    logic         busy;
    logic         done;

    modport slave  (input start, j, xin, output xref, symbol, busy, done);
    modport master (output start, j, xin, input xref, symbol, busy, done);
endinterface

// File: rtl/rice_preproc.sv
// Forward CCSDS-121 unit-delay preprocessor: maps each sample against its predecessor,
// producing one mapped residual per clock after a block is accepted.
module rice_preproc (
    input  logic          clk,
    input  logic          reset,
    rice_preproc_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t      state_q, state_d;
    logic [5:0]  count_q, count_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [5:0]  jeff_q;
    logic [5:0]  jeffIn;
    logic [9:0]  xref_q;
    logic [9:0]  sample_q [32];
    logic [9:0]  slot_q [32];
    logic        accept;
    logic [4:0]  slotIdx;
    logic [9:0]  mapped;

    // Residuals inside +/-theta interleave as 0,1,2,...; larger ones sit above 2*theta.
    function automatic logic [9:0] mapResidual(input logic [9:0] cur, input logic [9:0] prev);
        logic signed [11:0] delta;
        logic [9:0]         theta;
        logic [10:0]        mag;
        logic [9:0]         result;
        delta = $signed({2'b00, cur}) - $signed({2'b00, prev});
        theta = (prev < (10'd1023 - prev)) ? prev : (10'd1023 - prev);
        mag   = delta[11] ? 11'(-delta) : delta[10:0];
        if (!delta[11] && (mag <= {1'b0, theta})) begin
            result = 10'(mag << 1);
        end else if (delta[11] && (mag <= {1'b0, theta})) begin
            result = 10'((mag << 1) - 11'd1);
        end else begin
            result = 10'({1'b0, theta} + mag);
        end
        return result;
    endfunction

    assign jeffIn  = ((bus.j == 6'd0) || (bus.j > 6'd32)) ? 6'd32 : bus.j;
    assign accept  = (state_q == IDLE) && bus.start;
    assign slotIdx = count_q[4:0];
    assign mapped  = mapResidual(sample_q[slotIdx], sample_q[slotIdx - 5'd1]);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            count_q <= 6'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    count_d = 6'd1;
                    state_d = (jeffIn == 6'd1) ? DONE : RUN;
                end
            end
            RUN: begin
                count_d = count_q + 6'd1;
                if (count_q == (jeff_q - 6'd1)) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Flags follow the upcoming state so they appear registered in the same cycle as it.
    always_comb begin
        busy_d = (state_d == RUN);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            jeff_q <= 6'd0;
            xref_q <= 10'd0;
            for (int k = 0; k < 32; k++) begin
                sample_q[k] <= 10'd0;
                slot_q[k]   <= 10'd0;
            end
        end else if (accept) begin
            jeff_q <= jeffIn;
            xref_q <= bus.xin[9:0];
            for (int k = 0; k < 32; k++) begin
                sample_q[k] <= bus.xin[k*10 +: 10];
                slot_q[k]   <= 10'd0;
            end
        end else if (state_q == RUN) begin
            slot_q[slotIdx] <= mapped;
        end
    end

    assign bus.xref = xref_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;

    for (genvar k = 0; k < 32; k++) begin : g_symbol
        assign bus.symbol[k*10 +: 10] = slot_q[k];
    end
endmodule

// File: tb/tb_rice_preproc.sv
// Directed bench for rice_preproc: hand-computed residual vectors, boundary lengths,
// mid-block reset, ignored restarts, and random blocks reconstructed through an inverse mapper.
module tb_rice_preproc;
    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   failures = 0;

    rice_preproc_if dutIf();

    rice_preproc dut (
        .clk   (clk),
        .reset (reset),
        .bus   (dutIf.slave)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [319:0] obs, input logic [319:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic checkInt(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [319:0] randomVec();
        logic [319:0] v;
        for (int k = 0; k < 32; k++) v[k*10 +: 10] = 10'($urandom_range(0, 1023));
        return v;
    endfunction

    // Decoder side: rebuilds samples from the reference and the mapped residuals.
    function automatic logic [319:0] invpre(input logic [9:0] xr, input logic [319:0] sym, input int jeff);
        logic [319:0] r;
        int prev, s, th, d;
        r = '0;
        r[9:0] = xr;
        prev = int'(xr);
        for (int k = 1; k < jeff; k++) begin
            s  = int'(sym[k*10 +: 10]);
            th = (prev < 1023 - prev) ? prev : 1023 - prev;
            if (s <= 2 * th) d = (s % 2 == 0) ? s / 2 : -((s + 1) / 2);
            else if (th == prev) d = s - th;
            else d = th - s;
            prev = prev + d;
            r[k*10 +: 10] = 10'(prev);
        end
        return r;
    endfunction

    // Starts one block and waits (bounded) for done; returns the edge index done followed.
    task automatic applyStimulus(input logic [5:0] jv, input logic [319:0] xv, input bit disturb,
                                 output int doneEdge, output bit busyOk);
        int e;
        bit seen;
        @(negedge clk);
        dutIf.start = 1'b1;
        dutIf.j     = jv;
        dutIf.xin   = xv;
        @(posedge clk);
        #1;
        dutIf.start = 1'b0;
        if (disturb) begin
            dutIf.xin = randomVec();
            dutIf.j   = 6'($urandom);
        end
        e = 0;
        seen = 1'b0;
        busyOk = 1'b1;
        doneEdge = -1;
        while (!seen && e < 40) begin
            @(negedge clk);
            if (dutIf.done === 1'b1) begin
                seen = 1'b1;
                doneEdge = e;
                if (dutIf.busy !== 1'b0) busyOk = 1'b0;
            end else begin
                if (dutIf.busy !== 1'b1) busyOk = 1'b0;
                if (disturb) begin
                    dutIf.start = 1'($urandom);
                    dutIf.xin   = randomVec();
                    dutIf.j     = 6'($urandom);
                end
                @(posedge clk);
                e++;
            end
        end
        dutIf.start = 1'b0;
    endtask

    initial begin
        logic [319:0] flatVec, rampVec, rampSym, shortVec, shortSym, vec, work;
        int  doneEdge;
        bit  busyOk;
        int  jv;

        for (int k = 0; k < 32; k++) begin
            flatVec[k*10 +: 10]  = 10'd512;
            rampVec[k*10 +: 10]  = 10'(100 + k);
            rampSym[k*10 +: 10]  = (k == 0) ? 10'd0 : 10'd2;
            shortVec[k*10 +: 10] = 10'd777;
        end
        shortVec[49:0] = {10'd0, 10'd1023, 10'd1000, 10'd5, 10'd10};
        shortSym = '0;
        shortSym[49:10] = {10'd1023, 10'd46, 10'd1000, 10'd9};

        reset = 1'b0;
        dutIf.start = 1'b0;
        dutIf.j = 6'd0;
        dutIf.xin = '0;
        #12;
        checkOutput("reset xref", 320'(dutIf.xref), '0);
        checkOutput("reset symbol", dutIf.symbol, '0);
        checkInt("reset busy", int'(dutIf.busy), 0);
        checkInt("reset done", int'(dutIf.done), 0);
        @(negedge clk);
        reset = 1'b1;

        applyStimulus(6'd32, flatVec, 1'b0, doneEdge, busyOk);
        checkOutput("flat xref", 320'(dutIf.xref), 320'h200);
        checkOutput("flat symbol", dutIf.symbol, '0);
        checkInt("flat done edge", doneEdge, 31);
        checkInt("flat busy window", int'(busyOk), 1);
        @(negedge clk);
        checkInt("flat done pulse width", int'(dutIf.done), 0);

        applyStimulus(6'd32, rampVec, 1'b0, doneEdge, busyOk);
        checkOutput("ramp xref", 320'(dutIf.xref), 320'(10'd100));
        checkOutput("ramp symbol", dutIf.symbol, rampSym);
        checkInt("ramp done edge", doneEdge, 31);

        applyStimulus(6'd5, shortVec, 1'b0, doneEdge, busyOk);
        checkOutput("j5 xref", 320'(dutIf.xref), 320'(10'd10));
        checkOutput("j5 symbol", dutIf.symbol, shortSym);
        checkInt("j5 done edge", doneEdge, 4);
        checkInt("j5 busy window", int'(busyOk), 1);
        dutIf.xin = randomVec();
        dutIf.j = 6'd9;
        repeat (3) @(negedge clk);
        checkOutput("j5 hold symbol", dutIf.symbol, shortSym);
        checkOutput("j5 hold xref", 320'(dutIf.xref), 320'(10'd10));

        applyStimulus(6'd1, rampVec, 1'b0, doneEdge, busyOk);
        checkOutput("j1 xref", 320'(dutIf.xref), 320'(10'd100));
        checkOutput("j1 symbol", dutIf.symbol, '0);
        checkInt("j1 done edge", doneEdge, 0);
        checkInt("j1 busy low", int'(busyOk), 1);

        applyStimulus(6'd0, rampVec, 1'b0, doneEdge, busyOk);
        checkOutput("j0 symbol", dutIf.symbol, rampSym);
        checkInt("j0 done edge", doneEdge, 31);

        applyStimulus(6'd45, rampVec, 1'b0, doneEdge, busyOk);
        checkOutput("j45 symbol", dutIf.symbol, rampSym);
        checkInt("j45 done edge", doneEdge, 31);

        @(negedge clk);
        dutIf.start = 1'b1;
        dutIf.j = 6'd32;
        dutIf.xin = rampVec;
        @(posedge clk);
        #1;
        dutIf.start = 1'b0;
        repeat (9) @(posedge clk);
        #2;
        checkInt("abort pre slot9", int'(dutIf.symbol[99:90]), 2);
        checkInt("abort pre slot10", int'(dutIf.symbol[109:100]), 0);
        checkInt("abort pre busy", int'(dutIf.busy), 1);
        reset = 1'b0;
        #1;
        checkOutput("abort xref", 320'(dutIf.xref), '0);
        checkOutput("abort symbol", dutIf.symbol, '0);
        checkInt("abort busy", int'(dutIf.busy), 0);
        checkInt("abort done", int'(dutIf.done), 0);
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checkInt("abort idle busy", int'(dutIf.busy), 0);
        checkInt("abort idle done", int'(dutIf.done), 0);
        applyStimulus(6'd32, rampVec, 1'b0, doneEdge, busyOk);
        checkOutput("after abort xref", 320'(dutIf.xref), 320'(10'd100));
        checkOutput("after abort symbol", dutIf.symbol, rampSym);
        checkInt("after abort done edge", doneEdge, 31);

        applyStimulus(6'd5, shortVec, 1'b1, doneEdge, busyOk);
        checkOutput("disturbed symbol", dutIf.symbol, shortSym);
        checkOutput("disturbed xref", 320'(dutIf.xref), 320'(10'd10));
        checkInt("disturbed done edge", doneEdge, 4);
        checkInt("disturbed busy window", int'(busyOk), 1);

        for (int n = 0; n < 4; n++) begin
            vec = randomVec();
            jv = (n == 0) ? 32 : $urandom_range(2, 32);
            applyStimulus(6'(jv), vec, 1'b0, doneEdge, busyOk);
            work = '0;
            for (int k = 0; k < jv; k++) work[k*10 +: 10] = vec[k*10 +: 10];
            checkOutput("random invpre", invpre(dutIf.xref, dutIf.symbol, jv), work);
            checkInt("random slot0", int'(dutIf.symbol[9:0]), 0);
            work = dutIf.symbol;
            for (int k = 0; k < jv; k++) work[k*10 +: 10] = 10'd0;
            checkOutput("random tail zero", work, '0);
            checkInt("random done edge", doneEdge, jv - 1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
